neuron_activation_writeback: RTL and testbench
==============================================

// Module: neuron_activation_writeback
// PURPOSE
//  Downstream stage of the neuron MAC. Takes each finished accumulator sum (Q16.14) and adds the neuron bias.
//  Rounds and saturates the result to Q8.7, applies an optional ReLU, and writes it to the layer output BRAM.
//  The BRAM address auto-increments; one layer = NUM_NEURONS results. Feeds the next layer's input BRAM.
// PARAMETERS
//  ACC_W        32   accumulator input width, signed, ACC_FRAC fractional bits
//  ACC_FRAC     14   fractional bits of pi_acc_data (Q8.7 x Q8.7 product)
//  DATA_W       16   output/bias width, signed Q8.7
//  DATA_FRAC    7    fractional bits of output and bias
//  ADDR_W       16   BRAM address width
//  NUM_NEURONS  10   results written per layer
// PORTS
//  pi_clk          in   1       clock, all logic on rising edge
//  pi_rst          in   1       synchronous reset, active-high
//  pi_start        in   1       1-cycle pulse: latch pi_base_addr, begin layer
//  pi_base_addr    in   ADDR_W  first BRAM address of this layer
//  pi_relu_en      in   1       1 = ReLU after saturation, 0 = linear; sampled with pi_acc_valid
//  pi_acc_valid    in   1       1-cycle pulse: pi_acc_data/pi_bias valid (driven by neuron accumulation_done)
//  pi_acc_data     in   ACC_W   signed accumulator sum
//  pi_bias         in   DATA_W  signed Q8.7 bias for this neuron
//  po_ready        out  1       1 while in RUN and accepted count < NUM_NEURONS
//  po_BRAM_en      out  1       BRAM write strobe, 1 cycle per result
//  po_BRAM_we      out  1       equal to po_BRAM_en
//  po_BRAM_add     out  ADDR_W  write address
//  po_BRAM_data    out  DATA_W  Q8.7 activation
//  po_layer_done   out  1       1-cycle pulse after last write of the layer
//  po_sat_flag     out  1       sticky: any clamp occurred this layer; cleared on pi_start
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs 0; address and both counters 0; pipeline valids 0. Reset mid-layer aborts
//   the layer: in-flight results are dropped and no write or done pulse follows.
//  FSM IDLE: pi_acc_valid ignored. pi_start -> RUN, addr<=pi_base_addr, counters<=0, sat_flag<=0.
//  FSM RUN: pi_acc_valid accepted only when po_ready=1; accept increments in_cnt.
//   pi_start in RUN is ignored. On the write of result NUM_NEURONS-1 -> DONE.
//  FSM DONE: po_layer_done=1 for exactly this cycle, then IDLE. pi_start in DONE is ignored.
//  Stage 1 (cycle after accept): sum = sext(pi_acc_data) + (sext(pi_bias) << (ACC_FRAC-DATA_FRAC)), ACC_W+1 bits.
//   Also registers relu_en.
//  Stage 2: r = (sum + 2^(ACC_FRAC-DATA_FRAC-1)) >>> (ACC_FRAC-DATA_FRAC); the shift is arithmetic, so
//   rounding is half-up toward +inf. Clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets po_sat_flag.
//   If relu_en and the result is negative, the result becomes 0.
//  Stage 2 outputs are registered: po_BRAM_en=po_BRAM_we=1 and po_BRAM_data=result, both for 1 cycle.
//   po_BRAM_add = base + out_cnt. Address increments after each write and wraps modulo 2^ADDR_W.
//  Latency: accept on cycle N -> po_BRAM_en high on cycle N+2. Throughput 1 result/cycle (back-to-back valids).
//  po_layer_done is high in the cycle after the last po_BRAM_en.
//  po_BRAM_add/po_BRAM_data hold their last values when po_BRAM_en=0.
//  po_sat_flag stays set through DONE and IDLE until the next pi_start or pi_rst.
// TESTING
//  T1 round/bias: base=0, relu=0; acc=106496 (6.5), bias=128 (1.0) -> cycle+2: en=1, add=0, data=0x03C0 (7.5).
//  T2 rounding: acc=64, bias=0 -> data=0x0001; acc=63, bias=0 -> data=0x0000.
//   acc=-65, bias=0 -> data=0xFFFF (-1/128).
//  T3 saturation + ReLU: acc=4915200 (300.0) -> 0x7FFF, sat_flag=1.
//   acc=-49152 (-3.0) with relu=1 -> 0x0000; same with relu=0 -> 0xFE80.
//  T4 full layer: pi_start, base=0x0100, 10 back-to-back valids -> 10 writes at 0x0100..0x0109 on consecutive cycles.
//   po_layer_done pulses the cycle after the 0x0109 write. An 11th valid is ignored (po_ready=0, no write).
//  T5 wrap/ignored start: base=0xFFFE, 3 valids -> addresses 0xFFFE, 0xFFFF, 0x0000.
//   A pi_start during RUN does not change the address sequence or clear po_sat_flag.
//  T6 reset mid-layer: assert pi_rst after 4 accepts, 1 cycle after the 4th -> no further po_BRAM_en.
//   All outputs 0 next cycle. A new pi_start+10 valids completes normally from the new base.

Source files
------------

// File: rtl/neuron_activation_writeback.sv
// Activation writeback: adds bias to a Q16.14 accumulator sum, rounds/saturates to Q8.7,
// applies optional ReLU and streams results to the layer output BRAM at auto-incrementing addresses.
module neuron_activation_writeback #(
    parameter int ACC_W       = 32,
    parameter int ACC_FRAC    = 14,
    parameter int DATA_W      = 16,
    parameter int DATA_FRAC   = 7,
    parameter int ADDR_W      = 16,
    parameter int NUM_NEURONS = 10
) (
    input  logic              pi_clk,
    input  logic              pi_rst,
    input  logic              pi_start,
    input  logic [ADDR_W-1:0] pi_base_addr,
    input  logic              pi_relu_en,
    input  logic              pi_acc_valid,
    input  logic [ACC_W-1:0]  pi_acc_data,
    input  logic [DATA_W-1:0] pi_bias,
    output logic              po_ready,
    output logic              po_BRAM_en,
    output logic              po_BRAM_we,
    output logic [ADDR_W-1:0] po_BRAM_add,
    output logic [DATA_W-1:0] po_BRAM_data,
    output logic              po_layer_done,
    output logic              po_sat_flag
);

    localparam int SHIFT = ACC_FRAC - DATA_FRAC;
    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = $clog2(NUM_NEURONS + 1);
    localparam int ROUND = 1 << (SHIFT - 1);

    localparam logic signed [SUM_W:0] OUT_MAX = (SUM_W+1)'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [SUM_W:0] OUT_MIN = (SUM_W+1)'(-(2 ** (DATA_W - 1)));
    localparam logic [CNT_W-1:0]      CNT_END = CNT_W'(NUM_NEURONS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(NUM_NEURONS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state;
    logic [CNT_W-1:0]        in_cnt;
    logic [CNT_W-1:0]        out_cnt;
    logic [ADDR_W-1:0]       addr;
    logic                    s1_valid;
    logic                    s1_relu;
    logic signed [SUM_W-1:0] s1_sum;
    logic                    last_wr;

    logic                    accept;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] bias_ext;
    logic signed [SUM_W:0]   rounded;
    logic signed [SUM_W:0]   shifted;
    logic                    clip_hi;
    logic                    clip_lo;
    logic [DATA_W-1:0]       result;

    assign po_ready      = (state == S_RUN) && (in_cnt < CNT_END);
    assign accept        = pi_acc_valid && po_ready;
    assign po_BRAM_we    = po_BRAM_en;
    assign po_layer_done = (state == S_DONE);

    // Bias is aligned to the accumulator's binary point before the add.
    assign acc_ext  = SUM_W'(signed'(pi_acc_data));
    assign bias_ext = SUM_W'(signed'(pi_bias)) <<< SHIFT;

    // The arithmetic shift floors, so adding half an LSB first gives round-half-up.
    assign rounded = {s1_sum[SUM_W-1], s1_sum} + (SUM_W+1)'(ROUND);
    assign shifted = rounded >>> SHIFT;
    assign clip_hi = shifted > OUT_MAX;
    assign clip_lo = shifted < OUT_MIN;

    // NOTE: every path assigns result first, so this block stays purely combinational (no latch).
    always_comb begin
        result = shifted[DATA_W-1:0];
        if (clip_hi)
            result = {1'b0, {(DATA_W-1){1'b1}}};
        else if (clip_lo)
            result = {1'b1, {(DATA_W-1){1'b0}}};
        if (s1_relu && result[DATA_W-1])
            result = '0;
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state        <= S_IDLE;
            in_cnt       <= '0;
            out_cnt      <= '0;
            addr         <= '0;
            s1_valid     <= 1'b0;
            s1_relu      <= 1'b0;
            s1_sum       <= '0;
            last_wr      <= 1'b0;
            po_BRAM_en   <= 1'b0;
            po_BRAM_add  <= '0;
            po_BRAM_data <= '0;
            po_sat_flag  <= 1'b0;
        end else begin
            po_BRAM_en <= 1'b0;
            last_wr    <= 1'b0;
            s1_valid   <= accept;

            if (accept) begin
                s1_sum  <= acc_ext + bias_ext;
                s1_relu <= pi_relu_en;
                in_cnt  <= in_cnt + 1'b1;
            end

            if (s1_valid) begin
                po_BRAM_en   <= 1'b1;
                po_BRAM_data <= result;
                po_BRAM_add  <= addr;
                addr         <= addr + 1'b1;
                out_cnt      <= out_cnt + 1'b1;
                last_wr      <= (out_cnt == CNT_LAST);
                if (clip_hi || clip_lo)
                    po_sat_flag <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (pi_start) begin
                        state       <= S_RUN;
                        addr        <= pi_base_addr;
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        po_sat_flag <= 1'b0;
                    end
                end
                S_RUN:   if (last_wr) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_activation_writeback.sv
// Directed bench for neuron_activation_writeback: rounding, saturation, ReLU,
// full layers, address wrap, ignored starts and reset mid-layer.
module tb_neuron_activation_writeback;

    logic        pi_clk = 1'b0;
    logic        pi_rst = 1'b1;
    logic        pi_start = 1'b0;
    logic [15:0] pi_base_addr = '0;
    logic        pi_relu_en = 1'b0;
    logic        pi_acc_valid = 1'b0;
    logic [31:0] pi_acc_data = '0;
    logic [15:0] pi_bias = '0;
    logic        po_ready, po_BRAM_en, po_BRAM_we, po_layer_done, po_sat_flag;
    logic [15:0] po_BRAM_add, po_BRAM_data;

    int vectors = 0;
    int errors  = 0;

    neuron_activation_writeback dut (
        .pi_clk(pi_clk), .pi_rst(pi_rst), .pi_start(pi_start), .pi_base_addr(pi_base_addr),
        .pi_relu_en(pi_relu_en), .pi_acc_valid(pi_acc_valid), .pi_acc_data(pi_acc_data),
        .pi_bias(pi_bias), .po_ready(po_ready), .po_BRAM_en(po_BRAM_en), .po_BRAM_we(po_BRAM_we),
        .po_BRAM_add(po_BRAM_add), .po_BRAM_data(po_BRAM_data), .po_layer_done(po_layer_done),
        .po_sat_flag(po_sat_flag)
    );

    always #5 pi_clk = ~pi_clk;

    task automatic step();
        @(posedge pi_clk);
        #1;
    endtask

    task automatic start_layer(input logic [15:0] base);
        pi_start     = 1'b1;
        pi_base_addr = base;
        step();
        pi_start = 1'b0;
    endtask

    // One isolated result: accept, then write two cycles later, then idle/hold cycle.
    task automatic send_one(input logic [31:0] acc, input logic [15:0] bias, input logic relu,
                            input logic [15:0] exp_add, input logic [15:0] exp_data,
                            input logic exp_sat, input logic is_last, input string name);
        pi_acc_valid = 1'b1; pi_acc_data = acc; pi_bias = bias; pi_relu_en = relu;
        step();
        pi_acc_valid = 1'b0; pi_relu_en = ~relu;
        vectors++;
        if (po_BRAM_en !== 1'b0) begin
            errors++; $display("FAIL %s early_en: got %b want 0", name, po_BRAM_en);
        end
        step();
        vectors++;
        if (po_BRAM_en !== 1'b1 || po_BRAM_we !== 1'b1 || po_BRAM_add !== exp_add || po_BRAM_data !== exp_data) begin
            errors++;
            $display("FAIL %s write: got en=%b we=%b add=%h data=%h want en=1 we=1 add=%h data=%h",
                     name, po_BRAM_en, po_BRAM_we, po_BRAM_add, po_BRAM_data, exp_add, exp_data);
        end
        step();
        vectors++;
        if (po_BRAM_en !== 1'b0 || po_BRAM_add !== exp_add || po_BRAM_data !== exp_data ||
            po_sat_flag !== exp_sat || po_layer_done !== is_last) begin
            errors++;
            $display("FAIL %s hold: got en=%b add=%h data=%h sat=%b done=%b want en=0 add=%h data=%h sat=%b done=%b",
                     name, po_BRAM_en, po_BRAM_add, po_BRAM_data, po_sat_flag, po_layer_done,
                     exp_add, exp_data, exp_sat, is_last);
        end
    endtask

    // Full layer of back-to-back valids (acc = k.0, bias 0 -> data k*128) plus one extra valid.
    task automatic run_layer(input logic [15:0] base, input string name);
        start_layer(base);
        vectors++;
        if (po_sat_flag !== 1'b0 || po_ready !== 1'b1) begin
            errors++; $display("FAIL %s start: got sat=%b ready=%b want sat=0 ready=1", name, po_sat_flag, po_ready);
        end
        for (int k = 0; k < 13; k++) begin
            if (k <= 10) begin
                vectors++;
                if (po_ready !== (k < 10)) begin
                    errors++; $display("FAIL %s ready[%0d]: got %b want %b", name, k, po_ready, k < 10);
                end
            end
            pi_acc_valid = (k < 11);
            pi_acc_data  = 32'(k * 16384);
            pi_bias      = '0;
            pi_relu_en   = 1'b0;
            step();
            vectors++;
            if (k >= 1 && k <= 10) begin
                if (po_BRAM_en !== 1'b1 || po_BRAM_add !== base + 16'(k - 1) ||
                    po_BRAM_data !== 16'((k - 1) * 128) || po_layer_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got en=%b add=%h data=%h done=%b want en=1 add=%h data=%h done=0",
                             name, k - 1, po_BRAM_en, po_BRAM_add, po_BRAM_data, po_layer_done,
                             base + 16'(k - 1), 16'((k - 1) * 128));
                end
            end else begin
                if (po_BRAM_en !== 1'b0 || po_layer_done !== (k == 11)) begin
                    errors++;
                    $display("FAIL %s idle[%0d]: got en=%b done=%b want en=0 done=%b",
                             name, k, po_BRAM_en, po_layer_done, k == 11);
                end
            end
        end
        pi_acc_valid = 1'b0;
    endtask

    task automatic test_reset();
        pi_rst = 1'b1;
        step(); step();
        pi_rst = 1'b0;
        vectors++;
        if ({po_ready, po_BRAM_en, po_BRAM_we, po_BRAM_add, po_BRAM_data, po_layer_done, po_sat_flag} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b en=%b we=%b add=%h data=%h done=%b sat=%b want all 0",
                     po_ready, po_BRAM_en, po_BRAM_we, po_BRAM_add, po_BRAM_data, po_layer_done, po_sat_flag);
        end
        // Valids in IDLE must be ignored.
        pi_acc_valid = 1'b1; pi_acc_data = 32'd16384;
        step(); step();
        pi_acc_valid = 1'b0;
        vectors++;
        if (po_BRAM_en !== 1'b0) begin
            errors++; $display("FAIL idle_valid_ignored: got en=%b want 0", po_BRAM_en);
        end
    endtask

    task automatic test_round_sat_relu();
        start_layer(16'h0000);
        send_one(32'd106496, 16'd128, 1'b0, 16'h0000, 16'h03C0, 1'b0, 1'b0, "t1_bias");
        send_one(32'd64,     16'd0,   1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, "t2_half_up");
        send_one(32'd63,     16'd0,   1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, "t2_below_half");
        send_one(-32'sd65,   16'd0,   1'b0, 16'h0003, 16'hFFFF, 1'b0, 1'b0, "t2_neg");
        send_one(32'd4915200, 16'd0,  1'b0, 16'h0004, 16'h7FFF, 1'b1, 1'b0, "t3_sat_hi");
        send_one(-32'sd49152, 16'd0,  1'b1, 16'h0005, 16'h0000, 1'b1, 1'b0, "t3_relu_neg");
        send_one(-32'sd49152, 16'd0,  1'b0, 16'h0006, 16'hFE80, 1'b1, 1'b0, "t3_linear_neg");
        send_one(32'd0,      16'hFF80, 1'b0, 16'h0007, 16'hFF80, 1'b1, 1'b0, "neg_bias");
        send_one(32'd0,      16'hFF80, 1'b1, 16'h0008, 16'h0000, 1'b1, 1'b0, "neg_bias_relu");
        send_one(-32'sd4915200, 16'd0, 1'b0, 16'h0009, 16'h8000, 1'b1, 1'b1, "sat_lo_last");
        step();
        vectors++;
        if (po_layer_done !== 1'b0 || po_ready !== 1'b0 || po_sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL after_done: got done=%b ready=%b sat=%b want done=0 ready=0 sat=1",
                     po_layer_done, po_ready, po_sat_flag);
        end
    endtask

    task automatic test_full_layer();
        run_layer(16'h0100, "t4_layer");
    endtask

    task automatic test_wrap_ignored_start();
        logic [15:0] exp_add [3];
        logic [31:0] acc [3];
        logic [15:0] exp_data [3];
        exp_add  = '{16'hFFFE, 16'hFFFF, 16'h0000};
        acc      = '{32'd4915200, 32'd0, 32'd16384};
        exp_data = '{16'h7FFF, 16'h0000, 16'h0080};
        start_layer(16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            pi_acc_valid = 1'b1; pi_acc_data = acc[i]; pi_bias = '0; pi_relu_en = 1'b0;
            step();
            pi_acc_valid = 1'b0;
            pi_start = 1'b1; pi_base_addr = 16'h1234;
            step();
            pi_start = 1'b0;
            vectors++;
            if (po_BRAM_en !== 1'b1 || po_BRAM_add !== exp_add[i] || po_BRAM_data !== exp_data[i] || po_sat_flag !== 1'b1) begin
                errors++;
                $display("FAIL t5_wrap[%0d]: got en=%b add=%h data=%h sat=%b want en=1 add=%h data=%h sat=1",
                         i, po_BRAM_en, po_BRAM_add, po_BRAM_data, po_sat_flag, exp_add[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_reset_mid_layer();
        pi_rst = 1'b1;
        step();
        pi_rst = 1'b0;
        start_layer(16'h0040);
        for (int k = 0; k < 4; k++) begin
            pi_acc_valid = 1'b1; pi_acc_data = 32'd4915200; pi_bias = '0;
            step();
        end
        pi_acc_valid = 1'b0;
        pi_rst = 1'b1;
        step();
        pi_rst = 1'b0;
        vectors++;
        if ({po_ready, po_BRAM_en, po_BRAM_we, po_BRAM_add, po_BRAM_data, po_layer_done, po_sat_flag} !== '0) begin
            errors++;
            $display("FAIL t6_reset_outputs: got rdy=%b en=%b add=%h data=%h done=%b sat=%b want all 0",
                     po_ready, po_BRAM_en, po_BRAM_add, po_BRAM_data, po_layer_done, po_sat_flag);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            vectors++;
            if (po_BRAM_en !== 1'b0 || po_layer_done !== 1'b0) begin
                errors++; $display("FAIL t6_no_write[%0d]: got en=%b done=%b want 0 0", k, po_BRAM_en, po_layer_done);
            end
        end
        run_layer(16'h0200, "t6_relayer");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_sat_relu();
        test_full_layer();
        test_wrap_ignored_start();
        test_reset_mid_layer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
